// File: rtl/qam_demodulator_pkg.sv
// qam_demodulator_pkg: shared QAM code layout and demodulator FSM states.
// Contents: code field positions, qam_code_t, demod_state_t.
package qam_demodulator_pkg;
   localparam int I_MAG3 = 0;
   localparam int I_SIGN = 1;
   localparam int Q_MAG3 = 2;
   localparam int Q_SIGN = 3;
   typedef logic [3:0] qam_code_t;
   typedef enum logic {SEARCH, ACCUM} demod_state_t;
endpackage

// File: rtl/qam_demodulator_slicer.sv
// qam_slicer: decides one rail's {sign, mag3} from its correlation and carrier energy.
// Ports: acc_i signed correlation, en_i carrier energy, sign_o negative flag,
//        mag3_o set when |acc_i| >= 2*en_i (amplitude 3 rather than 1).
module qam_slicer #(
   parameter int ACC_W = 48
) (
   input  logic signed [ACC_W-1:0] acc_i,
   input  logic        [ACC_W-1:0] en_i,
   output logic                    sign_o,
   output logic                    mag3_o
);
   // one extra bit so the magnitude of the most negative value and 2*en never wrap
   logic signed [ACC_W:0] ext;
   logic        [ACC_W:0] mag;
   logic        [ACC_W:0] thr;
   assign ext    = acc_i;
   assign sign_o = acc_i[ACC_W-1];
   assign mag    = sign_o ? -ext : ext;
   assign thr    = {en_i, 1'b0};
   assign mag3_o = mag >= thr;
endmodule

// File: rtl/qam_demodulator.sv
// qam_demodulator: integrate-and-dump 16-QAM demodulator with symbol alignment.
// Ports: ipClk/ipReset (async, active-low); ipModulated + ipModulatedValid sample
//        stream; ipI/ipQ carrier references; ipAlign marks a symbol start;
//        opQAMBlock/opQAMBlockValid recovered code strobe; opAlignDiscard pulses
//        when a partial symbol is thrown away.
module qam_demodulator
   import qam_demodulator_pkg::*;
#(
   parameter int SAMPLES_PER_SYMBOL = 16,
   parameter int ACC_W              = 48
) (
   input  logic               ipClk,
   input  logic               ipReset,
   input  logic signed [19:0] ipModulated,
   input  logic               ipModulatedValid,
   input  logic signed [17:0] ipI,
   input  logic signed [17:0] ipQ,
   input  logic               ipAlign,
   output qam_code_t          opQAMBlock,
   output logic               opQAMBlockValid,
   output logic               opAlignDiscard
);
   localparam int CNT_W = (SAMPLES_PER_SYMBOL > 1) ? $clog2(SAMPLES_PER_SYMBOL) : 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(SAMPLES_PER_SYMBOL - 1);

   demod_state_t             state_q;
   logic [CNT_W-1:0]         cnt_q;
   logic [CNT_W-1:0]         idx_d;
   logic                     take_d, last_d, discard_d;
   logic signed [37:0]       pI_q, pQ_q;
   logic        [35:0]       eI_q, eQ_q;
   logic                     v1_q, first_q, last_q, discard_q;
   logic signed [ACC_W-1:0]  accI_q, accQ_q, dI_q, dQ_q;
   logic        [ACC_W-1:0]  enI_q, enQ_q, dEI_q, dEQ_q;
   logic                     pend_q, decide_q;
   logic                     i_sign, i_mag3, q_sign, q_mag3;
   qam_code_t                code_d, code_q;
   logic                     valid_q;

   // an aligned sample always restarts the symbol at index 0, whatever the counter says
   assign take_d    = ipModulatedValid & (ipAlign | (state_q == ACCUM));
   assign idx_d     = ipAlign ? '0 : cnt_q;
   assign last_d    = idx_d == LAST_IDX;
   assign discard_d = ipModulatedValid & ipAlign & (state_q == ACCUM) & (cnt_q != '0);

   // stage 1: lock/count FSM and products
   always_ff @(posedge ipClk or negedge ipReset) begin
      if (!ipReset) begin
         state_q   <= SEARCH;
         cnt_q     <= '0;
         v1_q      <= 1'b0;
         first_q   <= 1'b0;
         last_q    <= 1'b0;
         discard_q <= 1'b0;
         pI_q      <= '0;
         pQ_q      <= '0;
         eI_q      <= '0;
         eQ_q      <= '0;
      end else begin
         v1_q      <= take_d;
         discard_q <= discard_d;
         if (take_d) begin
            state_q <= ACCUM;
            cnt_q   <= last_d ? '0 : idx_d + 1'b1;
            first_q <= idx_d == '0;
            last_q  <= last_d;
            pI_q    <= ipModulated * ipI;
            pQ_q    <= ipModulated * ipQ;
            eI_q    <= ipI * ipI;
            eQ_q    <= ipQ * ipQ;
         end
      end
   end

   // stage 2: integrate, then hold the finished sums for the slicer
   always_ff @(posedge ipClk or negedge ipReset) begin
      if (!ipReset) begin
         accI_q   <= '0;
         accQ_q   <= '0;
         enI_q    <= '0;
         enQ_q    <= '0;
         pend_q   <= 1'b0;
         decide_q <= 1'b0;
         dI_q     <= '0;
         dQ_q     <= '0;
         dEI_q    <= '0;
         dEQ_q    <= '0;
      end else begin
         if (v1_q) begin
            accI_q <= first_q ? ACC_W'(pI_q) : accI_q + ACC_W'(pI_q);
            accQ_q <= first_q ? ACC_W'(pQ_q) : accQ_q + ACC_W'(pQ_q);
            enI_q  <= first_q ? ACC_W'(eI_q) : enI_q + ACC_W'(eI_q);
            enQ_q  <= first_q ? ACC_W'(eQ_q) : enQ_q + ACC_W'(eQ_q);
         end
         pend_q   <= v1_q & last_q;
         decide_q <= pend_q;
         if (pend_q) begin
            dI_q  <= accI_q;
            dQ_q  <= accQ_q;
            dEI_q <= enI_q;
            dEQ_q <= enQ_q;
         end
      end
   end

   qam_slicer #(.ACC_W(ACC_W)) u_slice_i (.acc_i(dI_q), .en_i(dEI_q), .sign_o(i_sign), .mag3_o(i_mag3));
   qam_slicer #(.ACC_W(ACC_W)) u_slice_q (.acc_i(dQ_q), .en_i(dEQ_q), .sign_o(q_sign), .mag3_o(q_mag3));

   always_comb begin
      code_d         = '0;
      code_d[I_SIGN] = i_sign;
      code_d[I_MAG3] = i_mag3;
      code_d[Q_SIGN] = q_sign;
      code_d[Q_MAG3] = q_mag3;
   end

   // stage 3: registered decision
   always_ff @(posedge ipClk or negedge ipReset) begin
      if (!ipReset) begin
         code_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= decide_q;
         if (decide_q) code_q <= code_d;
      end
   end

   assign opQAMBlock      = code_q;
   assign opQAMBlockValid = valid_q;
   assign opAlignDiscard  = discard_q;
endmodule

// File: tb/tb_qam_demodulator.sv
// tb_qam_demodulator: scoreboard bench for qam_demodulator with a symbol-level reference model.
module tb_qam_demodulator;
   logic               ipClk = 1'b0;
   logic               ipReset = 1'b0;
   logic signed [19:0] ipModulated = '0;
   logic               ipModulatedValid = 1'b0;
   logic signed [17:0] ipI = '0;
   logic signed [17:0] ipQ = '0;
   logic               ipAlign = 1'b0;
   logic [3:0]         opQAMBlock;
   logic               opQAMBlockValid;
   logic               opAlignDiscard;

   int total = 0;
   int bad = 0;
   int cyc = 0;

   typedef struct {
      logic [3:0] code;
      int         due;
   } exp_t;
   exp_t exp_q[$];
   int   disc_q[$];
   exp_t m_e;
   int   ci[4];
   int   cq[4];

   qam_demodulator #(.SAMPLES_PER_SYMBOL(4), .ACC_W(48)) dut (
      .ipClk(ipClk),
      .ipReset(ipReset),
      .ipModulated(ipModulated),
      .ipModulatedValid(ipModulatedValid),
      .ipI(ipI),
      .ipQ(ipQ),
      .ipAlign(ipAlign),
      .opQAMBlock(opQAMBlock),
      .opQAMBlockValid(opQAMBlockValid),
      .opAlignDiscard(opAlignDiscard)
   );

   always #5 ipClk = ~ipClk;
   always @(posedge ipClk) cyc <= cyc + 1;

   task automatic check(input string name, input longint got, input longint want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d (cycle %0d)", name, got, want, cyc);
      end
   endtask

   function automatic int amp(input logic [1:0] b);
      return b[1] ? (b[0] ? -3 : -1) : (b[0] ? 3 : 1);
   endfunction

   // symbol-level decision: correlation against carrier energy per rail
   function automatic logic [3:0] ref_code(input longint s_i, input longint e_i,
                                            input longint s_q, input longint e_q);
      logic [3:0] c;
      c[1] = s_i < 0;
      c[0] = (s_i < 0 ? -s_i : s_i) >= 2 * e_i;
      c[3] = s_q < 0;
      c[2] = (s_q < 0 ? -s_q : s_q) >= 2 * e_q;
      return c;
   endfunction

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge ipClk);
         #1 ipModulatedValid = 1'b0;
         ipAlign = 1'b0;
      end
   endtask

   task automatic drive(input int s, input int i_c, input int q_c, input bit al, input int gap);
      idle(gap);
      @(posedge ipClk);
      #1;
      ipModulated      = 20'(s);
      ipI              = 18'(i_c);
      ipQ              = 18'(q_c);
      ipAlign          = al;
      ipModulatedValid = 1'b1;
   endtask

   // amplitudes in hundredths; a full symbol pushes its expected code and due cycle
   task automatic send_symbol(input int a_i, input int a_q, input bit al, input int gap,
                              input bit disc, input int noise);
      longint s_i = 0, e_i = 0, s_q = 0, e_q = 0;
      int s;
      for (int k = 0; k < 4; k++) begin
         s = (a_i * ci[k] + a_q * cq[k]) / 100;
         if (noise != 0) s = s + int'($urandom_range(0, 2 * noise)) - noise;
         s_i += longint'(s) * ci[k];
         e_i += longint'(ci[k]) * ci[k];
         s_q += longint'(s) * cq[k];
         e_q += longint'(cq[k]) * cq[k];
         drive(s, ci[k], cq[k], al && k == 0, gap);
         if (disc && k == 0) disc_q.push_back(cyc + 1);
      end
      exp_q.push_back('{ref_code(s_i, e_i, s_q, e_q), cyc + 4});
   endtask

   task automatic send_partial(input int n, input bit al);
      for (int k = 0; k < n; k++) drive(100 * ci[k] / 100, ci[k], cq[k], al && k == 0, 0);
   endtask

   always @(negedge ipClk) begin
      if (ipReset) begin
         if (opQAMBlockValid) begin
            if (exp_q.size() == 0) check("unexpected_output", 1, 0);
            else begin
               m_e = exp_q.pop_front();
               check("code", opQAMBlock, m_e.code);
               check("latency_cycle", cyc, m_e.due);
            end
         end else if (exp_q.size() != 0 && cyc > exp_q[0].due) begin
            m_e = exp_q.pop_front();
            check("missing_output", 0, 1);
         end
         if (opAlignDiscard) begin
            if (disc_q.size() == 0) check("unexpected_discard", 1, 0);
            else check("discard_cycle", cyc, disc_q.pop_front());
         end else if (disc_q.size() != 0 && cyc > disc_q[0]) begin
            void'(disc_q.pop_front());
            check("missing_discard", 0, 1);
         end
      end
   end

   initial begin
      ci = '{1000, 0, -1000, 0};
      cq = '{0, 1000, 0, -1000};
      repeat (2) @(posedge ipClk);
      #1;
      check("reset_code", opQAMBlock, 0);
      check("reset_valid", opQAMBlockValid, 0);
      check("reset_discard", opAlignDiscard, 0);
      #2 ipReset = 1'b1;
      idle(2);
      // all 16 codes back to back
      for (int c = 0; c < 16; c++) send_symbol(100 * amp(2'(c)), 100 * amp(2'(c >> 2)), c == 0, 0, 0, 0);
      idle(6);
      // threshold: exact tie decodes as 3, just below decodes as 1
      send_symbol(200, 100, 1'b1, 0, 0, 0);
      send_symbol(199, 100, 1'b0, 0, 0, 0);
      send_symbol(-200, -300, 1'b0, 0, 0, 0);
      send_symbol(-199, 300, 1'b0, 0, 0, 0);
      idle(6);
      // valid toggling 1-0-1-0
      for (int c = 0; c < 16; c++) send_symbol(100 * amp(2'(c)), 100 * amp(2'(c >> 2)), c == 0, 1, 0, 0);
      idle(6);
      // align on the 3rd sample of a symbol drops the partial symbol
      send_partial(2, 1'b0);
      send_symbol(100 * amp(2'b11), 100 * amp(2'b10), 1'b1, 0, 1'b1, 0);
      send_symbol(100 * amp(2'b10), 100 * amp(2'b01), 1'b0, 0, 0, 0);
      idle(8);
      check("held_code_before_reset", opQAMBlock, 4'b0110);
      // asynchronous reset mid-symbol
      send_partial(2, 1'b0);
      @(posedge ipClk);
      #3 ipReset = 1'b0;
      #1;
      check("async_reset_code", opQAMBlock, 0);
      check("async_reset_valid", opQAMBlockValid, 0);
      check("async_reset_discard", opAlignDiscard, 0);
      idle(2);
      #3 ipReset = 1'b1;
      send_partial(4, 1'b0);
      send_partial(4, 1'b0);
      idle(8);
      send_symbol(100 * amp(2'b01), 100 * amp(2'b11), 1'b1, 0, 0, 0);
      // random carriers, amplitudes, noise and gaps
      for (int n = 0; n < 24; n++) begin
         for (int k = 0; k < 4; k++) begin
            ci[k] = int'($urandom_range(0, 40000)) - 20000;
            cq[k] = int'($urandom_range(0, 40000)) - 20000;
         end
         send_symbol(int'($urandom_range(0, 700)) - 350, int'($urandom_range(0, 700)) - 350,
                     n == 0, int'($urandom_range(0, 2)), 0, 30);
      end
      idle(1);
      for (int w = 0; w < 40 && (exp_q.size() != 0 || disc_q.size() != 0); w++) @(posedge ipClk);
      #1 check("scoreboard_empty", exp_q.size() + disc_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
